// File: rtl/packet_initiator.sv
// Initiator end of the serial point-to-point bus: frames a payload, shifts it out MSB-first,
// then waits for the responder's ACK/NACK and retransmits on NACK or timeout.
module packet_initiator #(
    parameter int unsigned FRAME_W   = 79,
    parameter int unsigned TIMEOUT   = 200,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  dest_addr,
    input  logic [3:0]  my_address,
    input  logic [1:0]  data_size,
    input  logic [63:0] data_in,
    input  logic [2:0]  crc_in,
    input  logic        serial_in,
    output logic        serial_out,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic [1:0]  retries
);

    localparam int unsigned BIT_W = $clog2(FRAME_W);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [BIT_W-1:0] LAST_TX     = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] LAST_RX     = BIT_W'(FRAME_W - 2);
    localparam logic [TMR_W-1:0] LAST_TMR    = TMR_W'(TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_EVAL,
        S_RETRY,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] tx;
    logic [FRAME_W-2:0] rx;
    logic [FRAME_W-1:0] new_frame;
    logic [BIT_W-1:0]   bit_cnt;
    logic [TMR_W-1:0]   tmr;
    logic [1:0]         retry_cnt;
    logic               ack_q;
    logic               addr_match;
    logic               is_ack;
    logic               can_retry;

    assign new_frame = {1'b0, my_address, dest_addr, data_size, data_in, crc_in, 1'b1};

    // The start bit is consumed in WAIT, so rx holds frame bits [77:0] at their own indices.
    assign addr_match = (rx[73:70] == frame[77:74]) && (rx[77:74] == frame[73:70]);
    assign is_ack     = rx[0] && (rx[69:68] == 2'b00) && (&rx[67:4]) && (&rx[3:1]);
    assign can_retry  = retry_cnt < RETRY_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        serial_out = 1'b1;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_SEND;
            S_SEND: begin
                serial_out = tx[FRAME_W-1];
                if (bit_cnt == LAST_TX) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!serial_in)            state_next = S_RECV;
                else if (tmr == LAST_TMR)  state_next = S_RETRY;
            end
            S_RECV:  if (bit_cnt == LAST_RX) state_next = S_EVAL;
            S_EVAL: begin
                if (!addr_match)  state_next = S_WAIT;
                else if (is_ack)  state_next = S_DONE;
                else              state_next = S_RETRY;
            end
            S_RETRY: state_next = can_retry ? S_SEND : S_DONE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame     <= '0;
            tx        <= '1;
            rx        <= '0;
            bit_cnt   <= '0;
            tmr       <= '0;
            retry_cnt <= '0;
            ack_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frame     <= new_frame;
                        tx        <= new_frame;
                        bit_cnt   <= '0;
                        retry_cnt <= '0;
                        ack_q     <= 1'b0;
                    end
                end
                S_SEND: begin
                    tx <= {tx[FRAME_W-2:0], 1'b1};
                    if (bit_cnt == LAST_TX) begin
                        bit_cnt <= '0;
                        tmr     <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                // The timeout counter holds across a discarded frame rather than restarting.
                S_WAIT: if (serial_in) tmr <= tmr + TMR_W'(1);
                S_RECV: begin
                    rx      <= {rx[FRAME_W-3:0], serial_in};
                    bit_cnt <= (bit_cnt == LAST_RX) ? '0 : bit_cnt + BIT_W'(1);
                end
                S_EVAL: ack_q <= addr_match && is_ack;
                S_RETRY: begin
                    if (can_retry) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        tx        <= frame;
                        bit_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack_ok  = ack_q;
    assign retries = retry_cnt;

endmodule

// File: tb/tb_packet_initiator.sv
// Bench for packet_initiator: acts as the addressed responder and checks transmitted frames,
// outcome and timing against a transaction-level model of the retry protocol.
module tb_packet_initiator;

    localparam int FW      = 79;
    localparam int TIMEOUT = 200;
    localparam int K_ACK   = 0;
    localparam int K_NACK  = 1;
    localparam int K_BAD   = 2;
    localparam int K_MIS   = 3;
    localparam int K_NONE  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  dest_addr;
    logic [3:0]  my_address;
    logic [1:0]  data_size;
    logic [63:0] data_in;
    logic [2:0]  crc_in;
    logic        serial_in;
    logic        serial_out;
    logic        busy;
    logic        done;
    logic        ack_ok;
    logic [1:0]  retries;

    int n_checks = 0;
    int n_errors = 0;

    // Response plan: per attempt, up to two frames, each preceded by a gap of idle-high cycles.
    int          n_items [4];
    int          gap     [4][2];
    int          kind    [4][2];
    logic [63:0] rdata   [4][2];
    logic [3:0]  org_my, org_dest;
    bit          poke_busy;
    bit          check_spacing;

    always #5 clk = ~clk;

    packet_initiator #(
        .FRAME_W  (79),
        .TIMEOUT  (200),
        .MAX_RETRY(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dest_addr (dest_addr),
        .my_address(my_address),
        .data_size (data_size),
        .data_in   (data_in),
        .crc_in    (crc_in),
        .serial_in (serial_in),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done),
        .ack_ok    (ack_ok),
        .retries   (retries)
    );

    task automatic check(input string tag, input logic [78:0] got, input logic [78:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [78:0] make_frame(input logic [3:0] src, input logic [3:0] dst,
                                               input logic [1:0] sz, input logic [63:0] d,
                                               input logic [2:0] c);
        return {1'b0, src, dst, sz, d, c, 1'b1};
    endfunction

    function automatic logic [78:0] rsp_frame(input int k, input logic [63:0] rd);
        case (k)
            K_ACK:   return make_frame(org_dest, org_my, 2'b00, '1, 3'b111);
            K_NACK:  return make_frame(org_dest, org_my, 2'b00, '0, 3'b000);
            K_BAD:   return make_frame(org_dest, org_my, 2'b00, rd, 3'b010);
            default: return make_frame(org_dest, org_my ^ 4'h6, 2'b00, '1, 3'b111);
        endcase
    endfunction

    task automatic clear_plan;
        for (int a = 0; a < 4; a++) begin
            n_items[a] = 0;
            for (int i = 0; i < 2; i++) begin
                gap[a][i]   = 0;
                kind[a][i]  = K_NONE;
                rdata[a][i] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic add_item(input int a, input int k, input int g);
        kind[a][n_items[a]] = k;
        gap[a][n_items[a]]  = g;
        n_items[a]++;
    endtask

    // Wait-counter value at each start bit: the first gap counts in full; after a discarded
    // frame one cycle goes to evaluation before waiting resumes from the held count.
    task automatic model(output int frames, output logic ack, output int rtr);
        bit fin = 0;
        frames = 4;
        ack    = 1'b0;
        rtr    = 3;
        for (int a = 0; a < 4; a++) begin
            if (!fin) begin
                int c  = 0;
                int oc = -1;
                for (int i = 0; i < n_items[a]; i++) begin
                    if (oc == -1) begin
                        c += (i == 0) ? gap[a][i] : gap[a][i] - 1;
                        if (c > TIMEOUT - 1)     oc = K_NONE;
                        else if (kind[a][i] != K_MIS) oc = kind[a][i];
                    end
                end
                if (oc == K_ACK) begin
                    fin    = 1;
                    ack    = 1'b1;
                    rtr    = a;
                    frames = a + 1;
                end
            end
        end
    endtask

    task automatic run_txn(input string name, input logic [3:0] my, input logic [3:0] dst,
                           input logic [1:0] sz, input logic [63:0] d, input logic [2:0] c);
        logic [78:0] caps[$];
        int          start_p[$];
        int          stop_p[$];
        logic        bq[$];
        logic [78:0] cap_sh, exp_frame, fr;
        int          cap_n, cyc, done_p, poke_p, exp_frames, exp_rtr;
        bit          capturing, done_seen;
        logic        got_ack, exp_ack;
        logic [1:0]  got_rtr;

        my_address = my;  dest_addr = dst;  data_size = sz;  data_in = d;  crc_in = c;
        org_my     = my;  org_dest  = dst;
        exp_frame  = make_frame(my, dst, sz, d, c);
        capturing  = 0;  cap_n = 0;  cap_sh = '0;  done_seen = 0;  done_p = 0;  poke_p = -1;
        got_ack    = 1'b0;  got_rtr = 2'd0;
        serial_in  = 1'b1;
        start      = 1'b1;
        tick;
        start = 1'b0;
        cyc   = 1;
        while (!done_seen && cyc < 6000) begin
            serial_in = (bq.size() > 0) ? bq.pop_front() : 1'b1;
            if (poke_p == cyc) begin
                start     = 1'b1;
                data_in   = ~d;
                dest_addr = dst ^ 4'hF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_seen = 1;
                done_p    = cyc;
                got_ack   = ack_ok;
                got_rtr   = retries;
                check({name, ".busy_with_done"}, busy, 1'b1);
            end
            if (capturing) begin
                cap_sh = {cap_sh[77:0], serial_out};
                cap_n++;
                if (cap_n == FW) begin
                    int a;
                    capturing = 0;
                    caps.push_back(cap_sh);
                    stop_p.push_back(cyc);
                    a = caps.size() - 1;
                    bq.delete();
                    if (a < 4) begin
                        for (int i = 0; i < n_items[a]; i++) begin
                            repeat (gap[a][i]) bq.push_back(1'b1);
                            fr = rsp_frame(kind[a][i], rdata[a][i]);
                            for (int b = FW - 1; b >= 0; b--) bq.push_back(fr[b]);
                        end
                    end
                    if (poke_busy && caps.size() == 1) poke_p = cyc + 3;
                end
            end else if (busy && serial_out == 1'b0) begin
                capturing = 1;
                cap_sh    = '0;
                cap_n     = 1;
                start_p.push_back(cyc);
            end
            if (!done_seen) begin
                tick;
                cyc++;
            end
        end
        start     = 1'b0;
        serial_in = 1'b1;

        model(exp_frames, exp_ack, exp_rtr);
        check({name, ".done_seen"}, done_seen, 1'b1);
        check({name, ".frames"}, caps.size(), exp_frames);
        foreach (caps[i]) check($sformatf("%s.frame%0d", name, i), caps[i], exp_frame);
        check({name, ".ack_ok"}, got_ack, exp_ack);
        check({name, ".retries"}, got_rtr, exp_rtr);
        if (exp_frames == 1 && n_items[0] == 1 && kind[0][0] == K_ACK)
            check({name, ".latency"}, done_p, 2 * FW + 2 + gap[0][0]);
        if (check_spacing)
            for (int i = 1; i < start_p.size(); i++)
                check($sformatf("%s.idle%0d", name, i), start_p[i] - stop_p[i-1] - 1, TIMEOUT + 1);
        if (done_seen) begin
            tick;
            check({name, ".done_width"}, done, 1'b0);
            check({name, ".busy_fall"}, busy, 1'b0);
            check({name, ".retries_held"}, retries, exp_rtr);
        end
        tick;
    endtask

    initial begin
        rst = 1'b1;  start = 1'b0;  serial_in = 1'b1;
        dest_addr = '0;  my_address = '0;  data_size = '0;  data_in = '0;  crc_in = '0;
        poke_busy = 0;  check_spacing = 0;
        tick;
        tick;
        check("rst.serial_out", serial_out, 1'b1);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.ack_ok", ack_ok, 1'b0);
        check("rst.retries", retries, 2'd0);
        rst = 1'b0;
        tick;

        clear_plan;
        add_item(0, K_ACK, 10);
        run_txn("clean", 4'h1, 4'h5, 2'b11, 64'hDEADBEEF_CAFEF00D, 3'b101);

        clear_plan;
        add_item(0, K_NACK, 20);
        add_item(1, K_ACK, 7);
        run_txn("nack_ack", 4'h2, 4'h9, 2'b01, 64'h0123_4567_89AB_CDEF, 3'b011);

        clear_plan;
        check_spacing = 1;
        run_txn("exhaust", 4'h4, 4'hC, 2'b10, 64'hA5A5_5A5A_F0F0_0F0F, 3'b110);
        check_spacing = 0;

        clear_plan;
        add_item(0, K_MIS, 5);
        add_item(0, K_ACK, 12);
        run_txn("misaddr", 4'h1, 4'h5, 2'b00, 64'h1111_2222_3333_4444, 3'b001);

        clear_plan;
        add_item(0, K_MIS, 5);
        add_item(0, K_ACK, 300);
        add_item(1, K_ACK, 10);
        run_txn("misaddr_late", 4'h1, 4'h5, 2'b00, 64'h5555_6666_7777_8888, 3'b100);

        // Reset in the middle of transmission.
        my_address = 4'h3;  dest_addr = 4'hA;  data_size = 2'b01;
        data_in = 64'hFEED_FACE_0BAD_F00D;  crc_in = 3'b010;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (40) tick;
        rst = 1'b1;
        #1;
        check("midrst.serial_out", serial_out, 1'b1);
        check("midrst.busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("midrst.no_done", done, 1'b0);
        end
        rst = 1'b0;
        tick;
        clear_plan;
        add_item(0, K_ACK, 4);
        run_txn("after_rst", 4'h3, 4'hA, 2'b10, 64'h0F1E_2D3C_4B5A_6978, 3'b111);

        clear_plan;
        add_item(0, K_NACK, 15);
        add_item(1, K_ACK, 3);
        poke_busy = 1;
        run_txn("busy_start", 4'h6, 4'h8, 2'b11, 64'h7777_0000_FFFF_1234, 3'b000);
        poke_busy = 0;

        for (int t = 0; t < 8; t++) begin
            clear_plan;
            for (int a = 0; a < 4; a++) begin
                int r = $urandom_range(0, 5);
                int g = $urandom_range(0, 120);
                case (r)
                    0, 1: add_item(a, K_ACK, g);
                    2:    add_item(a, K_NACK, g);
                    3:    add_item(a, K_BAD, g);
                    4:    ;
                    default: begin
                        add_item(a, K_MIS, g);
                        add_item(a, $urandom_range(0, 2), $urandom_range(2, 40));
                    end
                endcase
            end
            run_txn($sformatf("rand%0d", t), 4'($urandom), 4'($urandom), 2'($urandom),
                    {$urandom, $urandom}, 3'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_initiator.md
Name: packet_initiator

Overview:
- Initiator end of the serial point-to-point bus protocol.
- Frames a 64-bit payload into a 79-bit packet and shifts it MSB-first onto the serial line.
- Then listens for the addressed responder's ACK/NACK packet and retransmits on NACK or timeout, up to a retry limit.
- Sits between the host-side data source / CRC generator and the shared serial bus.

Parameters:
- FRAME_W, 79, packet length in bits.
- TIMEOUT, 200, clock cycles allowed between end of transmission and the response start bit.
- MAX_RETRY, 3, retransmissions allowed after the first attempt.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- dest_addr  input  4  responder address.
- my_address  input  4  own address; used as the source field.
- data_size  input  2  payload size code, copied into the frame.
- data_in  input  64  payload.
- crc_in  input  3  CRC of the payload, from an external generator.
- serial_in  input  1  bus receive line; idles high.
- serial_out  output  1  bus transmit line; idles high.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when the transaction ends.
- ack_ok  output  1  valid with done: 1 means ACK received, 0 means failure.
- retries  output  2  retransmission count of the last transaction; held until the next start.

Behaviour:
- Frame layout, MSB first:
  - bit78 start bit = 0
  - [77:74] source address
  - [73:70] destination address
  - [69:68] data_size
  - [67:4] data
  - [3:1] crc
  - bit0 stop bit = 1
- ACK frame: data all ones, crc 3'b111, data_size 0. NACK frame: data all zeros, crc 3'b000.
- Reset values: serial_out=1, busy=0, done=0, ack_ok=0, retries=0, state=IDLE, internal counters cleared.
- Reset is honoured mid-operation: serial_out returns to 1 immediately and no done pulse is generated.
- IDLE:
  - When start=1, latch all frame inputs into a 79-bit shift register, clear retries, go to SEND.
  - Inputs are not resampled during retries.
- SEND:
  - serial_out drives frame bit 78 in the first SEND cycle, then one bit per cycle.
  - Bit 0 goes out in the 79th cycle, then the state moves to WAIT.
  - serial_out=1 from the next cycle onward.
- WAIT:
  - Timeout counter counts from 0.
  - serial_in=0 seen starts reception: go to RECV, and that sample is frame bit 78.
  - Counter reaching TIMEOUT-1 with no start bit is a failure: go to RETRY.
- RECV:
  - Shift serial_in into the receive register for 78 more cycles, completing the 79-bit frame.
  - Then evaluate in one cycle.
- Evaluation, all conditions:
  - Destination field must equal my_address and source field must equal dest_addr; otherwise discard and return to WAIT with the timeout counter NOT reset.
  - Stop bit must be 1.
  - data==all-ones and crc==111 means ACK: go to DONE with ack_ok=1.
  - data==all-zeros and crc==000 means NACK: go to RETRY.
  - Any other content is malformed and treated as NACK.
- RETRY:
  - If retries < MAX_RETRY: increment retries, reload the shift register from latched values, go to SEND after one idle-high cycle.
  - Otherwise go to DONE with ack_ok=0.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done falls.
- A start asserted while busy is ignored.
- Latency, ACK on first try: done pulses 79 + response delay + 79 + 2 cycles after start.

Test Plan:
- Clean ACK: my_address=4'h1, dest=4'h5, data=64'hDEADBEEF_CAFEF00D, crc=3'b101, start; responder returns ACK 10 cycles after the stop bit.
  - Required: serial_out sequence is 0,0001,0101,size,data,101,1; done pulses with ack_ok=1 and retries=0.
- NACK then ACK: first response NACK, second ACK.
  - Required: exactly two identical 79-bit frames on serial_out; done with ack_ok=1 and retries=1.
- Timeout exhaustion: serial_in held at 1 throughout.
  - Required: 4 frames transmitted, each followed by a 200-cycle wait; done with ack_ok=0 and retries=3.
- Misaddressed response: ACK frame with destination 4'h7 arrives, then a correct ACK before the timeout.
  - Required: the first frame is ignored and the transaction completes with ack_ok=1, retries=0.
  - Variant: if the correct ACK arrives after the timeout, a retry occurs.
- Reset mid-SEND: assert rst at bit 40.
  - Required: serial_out=1 and busy=0 immediately, no done pulse; a new start afterwards sends a full fresh frame.
- Start while busy: pulse start during WAIT with different data.
  - Required: ignored; any retransmission carries the original data.
